// File: rtl/fir_burst_sequencer.sv
// fir_burst_sequencer: streams a programmable sample table into the FIR and counts returned results
// Ports: clk/reset (async, active-high); cfg_* loads the table and captures hold/len at start;
// start/abort control a burst; busy/done/status report it; m_axis_fir_* streams samples out;
// s_axis_res_* accepts filtered results; rx_count counts results accepted this burst.
module fir_burst_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int HOLD_W  = 4,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]   cfg_wdata,
  input  logic [HOLD_W-1:0]   cfg_hold,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [1:0]          status,
  output logic [DATA_W-1:0]   m_axis_fir_tdata,
  output logic                m_axis_fir_tvalid,
  input  logic                m_axis_fir_tready,
  output logic                m_axis_fir_tlast,
  output logic [DATA_W/8-1:0] m_axis_fir_tkeep,
  input  logic                s_axis_res_tvalid,
  output logic                s_axis_res_tready,
  output logic [LEN_W-1:0]    rx_count
);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ST_OK = 2'd0, ST_TIMEOUT = 2'd1, ST_ABORT = 2'd2;
  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [LEN_W-1:0] len, tx_cnt, rx_nxt;
  logic [HOLD_W-1:0] hold, rep;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic abort_pend, beat, acc;
  assign beat = m_axis_fir_tvalid & m_axis_fir_tready;
  assign acc = s_axis_res_tvalid & busy;
  assign s_axis_res_tready = busy;
  assign m_axis_fir_tkeep = '1;
  assign addr_nxt = (rep == hold) ? addr + 1'b1 : addr;
  assign rx_nxt = rx_count + LEN_W'(acc);
  always_ff @(posedge clk)
    if (cfg_we && !busy) mem[cfg_addr] <= cfg_wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      len <= '0;
      hold <= '0;
      tx_cnt <= '0;
      rep <= '0;
      addr <= '0;
      idle_cnt <= '0;
      abort_pend <= 1'b0;
      rx_count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      status <= ST_OK;
      m_axis_fir_tdata <= '0;
      m_axis_fir_tvalid <= 1'b0;
      m_axis_fir_tlast <= 1'b0;
    end else begin
      done <= 1'b0;
      rx_count <= rx_nxt;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          status <= ST_OK;
          len <= cfg_len;
          hold <= cfg_hold;
          tx_cnt <= '0;
          rep <= '0;
          addr <= '0;
          rx_count <= '0;
          idle_cnt <= '0;
          abort_pend <= 1'b0;
          if (cfg_len == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= SEND;
            m_axis_fir_tvalid <= 1'b1;
            m_axis_fir_tdata <= mem[ADDR_W'(0)];
            m_axis_fir_tlast <= (cfg_len == LEN_W'(1));
          end
        end
        SEND: if (beat) begin
          tx_cnt <= tx_cnt + LEN_W'(1);
          rep <= (rep == hold) ? '0 : rep + 1'b1;
          addr <= addr_nxt;
          m_axis_fir_tdata <= mem[addr_nxt];
          m_axis_fir_tlast <= (tx_cnt + LEN_W'(1) == len - LEN_W'(1));
          // an abort seen during a stall is only honoured once the held beat is taken
          if (abort || abort_pend) begin
            m_axis_fir_tvalid <= 1'b0;
            m_axis_fir_tlast <= 1'b0;
            state <= DONE;
            done <= 1'b1;
            status <= ST_ABORT;
          end else if (m_axis_fir_tlast) begin
            m_axis_fir_tvalid <= 1'b0;
            m_axis_fir_tlast <= 1'b0;
            idle_cnt <= '0;
            state <= DRAIN;
          end
        end else if (abort && !m_axis_fir_tvalid) begin
          state <= DONE;
          done <= 1'b1;
          status <= ST_ABORT;
        end else if (abort) abort_pend <= 1'b1;
        DRAIN: if (abort) begin
          state <= DONE;
          done <= 1'b1;
          status <= ST_ABORT;
        end else if (rx_nxt >= len) begin
          state <= DONE;
          done <= 1'b1;
          status <= ST_OK;
        end else if (acc) idle_cnt <= '0;
        else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
          state <= DONE;
          done <= 1'b1;
          status <= ST_TIMEOUT;
        end else idle_cnt <= idle_cnt + 1'b1;
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_fir_burst_sequencer.sv
// tb_fir_burst_sequencer: randomized self-checking bench against a table/beat-index reference model
module tb_fir_burst_sequencer;
  localparam int DW = 16, AW = 3, HW = 4, LW = 16, TO = 255;
  logic clk = 1'b0, reset;
  logic cfg_we, start, abort, busy, done, tvalid, tready, tlast, res_tvalid, res_tready;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata, tdata;
  logic [HW-1:0] cfg_hold;
  logic [LW-1:0] cfg_len, rx_count;
  logic [1:0] status;
  logic [DW/8-1:0] tkeep;
  logic [DW-1:0] tbl [8];
  int n_cmp = 0, n_bad = 0;

  fir_burst_sequencer #(.DATA_W(DW), .ADDR_W(AW), .HOLD_W(HW), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_hold(cfg_hold), .cfg_len(cfg_len), .start(start), .abort(abort), .busy(busy),
    .done(done), .status(status), .m_axis_fir_tdata(tdata), .m_axis_fir_tvalid(tvalid),
    .m_axis_fir_tready(tready), .m_axis_fir_tlast(tlast), .m_axis_fir_tkeep(tkeep),
    .s_axis_res_tvalid(res_tvalid), .s_axis_res_tready(res_tready), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cfg_we = 1'b1;
      cfg_addr = AW'(i);
      cfg_wdata = tbl[i];
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // mode 0: tready=1; 1: 10-cycle stall at beat 12; 2: random ready/results/blocked writes;
  // 3: 3-cycle stall at abort_beat with a one-cycle abort at its start
  task automatic burst(input int hold, input int len, input int mode, input int n_res,
                       input int abort_beat, input int exp_st);
    int beats, acc, ret, stall, cyc, last_cyc, done_cyc, exp_beats, exp_rx;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    beats = 0; acc = 0; ret = n_res; stall = 0; cyc = 0; last_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_data = '0;
    exp_beats = (abort_beat >= 0) ? abort_beat + 1 : len;
    @(posedge clk); #1;
    cfg_hold = HW'(hold);
    cfg_len = LW'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 3000) begin
      tready = (mode == 1) ? !(beats == 12 && stall < 10) :
               (mode == 3) ? !(beats == abort_beat && stall < 3) :
               (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
      abort = (mode == 3) && beats == abort_beat && stall == 0;
      if (!tready) stall++;
      res_tvalid = ret > 0 && acc < beats && !done && (mode != 2 || $urandom_range(0, 1) == 1);
      cfg_we = (mode == 2) && busy && $urandom_range(0, 1) == 1;
      cfg_addr = AW'($urandom);
      cfg_wdata = DW'($urandom);
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("stall_valid", tvalid, 1);
        chk("stall_data", tdata, prev_data);
      end
      if (tvalid) begin
        chk("tdata", tdata, tbl[(beats / (hold + 1)) % 8]);
        chk("tlast", tlast, beats == len - 1);
        prev_stall = !tready;
        prev_data = tdata;
        if (tready) begin
          if (tlast) last_cyc = cyc;
          beats++;
        end
      end else prev_stall = 1'b0;
      if (res_tvalid && res_tready) begin
        acc++;
        ret--;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    exp_rx = (exp_st == 0) ? len : (exp_st == 1) ? n_res : acc;
    chk("done_seen", done_cyc >= 0, 1);
    chk("status", status, exp_st);
    chk("beats", beats, exp_beats);
    chk("rx_count", rx_count, exp_rx);
    if (exp_st == 1) chk("timeout_cycles", done_cyc - last_cyc, TO + 1);
    @(posedge clk); #1;
    tready = 1'b0; res_tvalid = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("status_held", status, exp_st);
  endtask

  initial begin
    int done_at, hold_r, len_r;
    logic saw_valid;
    logic [1:0] st0;
    reset = 1'b1; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; cfg_hold = '0; cfg_len = '0;
    start = 0; abort = 0; tready = 0; res_tvalid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_count, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_status", status, 0);
    chk("rst_tready", res_tready, 0);
    chk("tkeep", tkeep, 2'b11);
    reset = 1'b0;
    tbl = '{16'h0000, 16'h5A7E, 16'h7FFF, 16'h5A7E, 16'h0000, 16'hA582, 16'h8000, 16'hA582};
    load_table();
    burst(4, 80, 0, 80, -1, 0);
    burst(4, 80, 1, 80, -1, 0);
    done_at = -1; saw_valid = 1'b0; st0 = 2'd3;
    @(posedge clk); #1;
    cfg_len = '0;
    start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (tvalid) saw_valid = 1'b1;
      if (done && done_at < 0) begin
        done_at = i;
        st0 = status;
      end
      if (i == 1) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk("len0_done_at", done_at, 2);
    chk("len0_tvalid", saw_valid, 0);
    chk("len0_status", st0, 0);
    burst(0, 4, 0, 2, -1, 1);
    burst(4, 40, 3, 40, 10, 2);
    @(posedge clk); #1;
    cfg_hold = 4'd4;
    cfg_len = 16'd80;
    start = 1'b1;
    tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    res_tvalid = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx", rx_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    res_tvalid = 1'b0;
    tready = 1'b0;
    burst(4, 80, 0, 80, -1, 0);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) tbl[i] = DW'($urandom);
      load_table();
      hold_r = $urandom_range(0, 15);
      len_r = $urandom_range(1, 40);
      burst(hold_r, len_r, 2, len_r, -1, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
